fp_exception_ctrl: RTL and testbench

Parametrised, pipelined successor of the combinational FPU exception detector. It classifies operand pairs for add/sub/mul/div, produces a 3-bit exception code plus a substitute (default) result, and keeps IEEE-style sticky flags, a saturating exception counter and a maskable interrupt. It sits between operand issue and the FPU datapath result mux, with valid/ready handshakes on both sides.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp_classify.sv | 34 +++
 rtl/fp_exception_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fp_exception_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU encodings: operation codes, exception codes and sticky-flag bit positions.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fp_op_e;

  typedef enum logic [2:0] {
    EXC_NONE     = 3'd0,
    EXC_SNAN     = 3'd1,
    EXC_QNAN     = 3'd2,
    EXC_INVALID  = 3'd3,
    EXC_DIV_ZERO = 3'd4
  } exc_code_e;

  localparam int unsigned STICKY_INVALID  = 0;
  localparam int unsigned STICKY_DIV_ZERO = 1;
  localparam int unsigned STICKY_QNAN     = 2;
  localparam int unsigned STICKY_W        = 3;

  // Trap-class codes raise exce; a quiet NaN only overrides the result.
  function automatic logic code_is_trap(input exc_code_e code);
    return (code == EXC_SNAN) || (code == EXC_INVALID) || (code == EXC_DIV_ZERO);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one floating-point operand of EXP_W/MAN_W format.
module fp_classify #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3
) (
  input  logic [EXP_W+MAN_W:0] operand,
  output logic                 sign,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_snan,
  output logic                 is_qnan
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             man_zero;
  logic             is_nan;

  assign exp_f    = operand[MAN_W +: EXP_W];
  assign man_f    = operand[MAN_W-1:0];
  assign sign     = operand[EXP_W+MAN_W];

  assign exp_ones = &exp_f;
  assign man_zero = (man_f == '0);
  assign is_nan   = exp_ones && !man_zero;

  // Mantissa MSB distinguishes quiet from signalling NaN; denormals fall through as finite.
  assign is_snan  = is_nan && !man_f[MAN_W-1];
  assign is_qnan  = is_nan &&  man_f[MAN_W-1];
  assign is_inf   = exp_ones && man_zero;
  assign is_zero  = (exp_f == '0) && man_zero;

endmodule

// File: rtl/fp_exception_ctrl.sv
// Pipelined FPU exception controller: classifies operand pairs, registers the exception
// code and substitute result, and tracks sticky flags, a saturating counter and an irq.
module fp_exception_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [EXP_W+MAN_W:0] in0,
  input  logic [EXP_W+MAN_W:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 exce,
  output logic [2:0]           exce_code,
  output logic                 result_override,
  output logic [EXP_W+MAN_W:0] exce_result,
  input  logic                 flag_clr,
  input  logic [2:0]           trap_en,
  output logic [2:0]           sticky_flags,
  output logic                 irq,
  output logic [CNT_W-1:0]     exce_count
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_QNAN = W'({(EXP_W+1){1'b1}}) << (MAN_W - 1);
  localparam logic [W-1:0] INF_MAG    = W'({EXP_W{1'b1}}) << MAN_W;

  logic s0, z0, i0, sn0, qn0;
  logic s1, z1, i1, sn1, qn1;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls0 (
    .operand (in0),
    .sign    (s0),
    .is_zero (z0),
    .is_inf  (i0),
    .is_snan (sn0),
    .is_qnan (qn0)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
    .operand (in1),
    .sign    (s1),
    .is_zero (z1),
    .is_inf  (i1),
    .is_snan (sn1),
    .is_qnan (qn1)
  );

  fp_op_e           op_e;
  logic             invalid_d;
  logic             div_zero_d;
  exc_code_e        code_d;
  logic [W-1:0]     result_d;
  logic             exce_d;
  logic             override_d;
  logic             fire;
  logic [2:0]       sticky_set;
  logic [2:0]       sticky_d;

  exc_code_e        code_q;
  logic             valid_q;
  logic             exce_q;
  logic             override_q;
  logic [W-1:0]     result_q;
  logic [2:0]       sticky_q;
  logic [CNT_W-1:0] count_q;

  assign op_e = fp_op_e'(op);

  always_comb begin
    invalid_d  = 1'b0;
    div_zero_d = 1'b0;
    case (op_e)
      OP_ADD:  invalid_d = i0 && i1 && (s0 != s1);
      OP_SUB:  invalid_d = i0 && i1 && (s0 == s1);
      OP_MUL:  invalid_d = (z0 && i1) || (i0 && z1);
      OP_DIV: begin
        invalid_d  = (z0 && z1) || (i0 && i1);
        div_zero_d = z1 && !z0 && !i0 && !sn0 && !qn0;
      end
      default: invalid_d = 1'b0;
    endcase
  end

  always_comb begin
    code_d   = EXC_NONE;
    result_d = '0;
    if (sn0 || sn1)
      code_d = EXC_SNAN;
    else if (qn0 || qn1)
      code_d = EXC_QNAN;
    else if (invalid_d)
      code_d = EXC_INVALID;
    else if (div_zero_d)
      code_d = EXC_DIV_ZERO;

    case (code_d)
      EXC_SNAN, EXC_INVALID: result_d = CANON_QNAN;
      EXC_QNAN:              result_d = qn0 ? in0 : in1;
      EXC_DIV_ZERO: begin
        result_d        = INF_MAG;
        result_d[W-1]   = s0 ^ s1;
      end
      default:               result_d = '0;
    endcase

    exce_d     = code_is_trap(code_d);
    override_d = (code_d != EXC_NONE);
  end

  assign in_ready = !valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  // A clear and a same-cycle set on one bit resolve in favour of the set.
  always_comb begin
    sticky_set = '0;
    if (fire) begin
      case (code_d)
        EXC_SNAN, EXC_INVALID: sticky_set[STICKY_INVALID]  = 1'b1;
        EXC_DIV_ZERO:          sticky_set[STICKY_DIV_ZERO] = 1'b1;
        EXC_QNAN:              sticky_set[STICKY_QNAN]     = 1'b1;
        default:               sticky_set = '0;
      endcase
    end
    sticky_d = (flag_clr ? '0 : sticky_q) | sticky_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      exce_q     <= 1'b0;
      code_q     <= EXC_NONE;
      override_q <= 1'b0;
      result_q   <= '0;
    end else if (fire) begin
      valid_q    <= 1'b1;
      exce_q     <= exce_d;
      code_q     <= code_d;
      override_q <= override_d;
      result_q   <= result_d;
    end else if (out_ready) begin
      valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (fire && exce_d && (count_q != '1))
        count_q <= count_q + CNT_W'(1);
    end
  end

  assign out_valid       = valid_q;
  assign exce            = exce_q;
  assign exce_code       = code_q;
  assign result_override = override_q;
  assign exce_result     = result_q;
  assign sticky_flags    = sticky_q;
  assign exce_count      = count_q;
  assign irq             = |(sticky_q & trap_en);

endmodule

// File: tb/tb_fp_exception_ctrl.sv
// Randomised and directed bench for fp_exception_ctrl (E4M3 defaults) with an arithmetic reference model.
module tb_fp_exception_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       out_valid;
  logic       out_ready;
  logic       exce;
  logic [2:0] exce_code;
  logic       result_override;
  logic [7:0] exce_result;
  logic       flag_clr;
  logic [2:0] trap_en;
  logic [2:0] sticky_flags;
  logic       irq;
  logic [7:0] exce_count;

  int total = 0;
  int bad   = 0;

  bit         m_valid;
  bit         m_exce;
  int         m_code;
  bit         m_ovr;
  logic [7:0] m_res;
  logic [2:0] m_sticky;
  int         m_count;

  fp_exception_ctrl #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op              (op),
    .in0             (in0),
    .in1             (in1),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .exce            (exce),
    .exce_code       (exce_code),
    .result_override (result_override),
    .exce_result     (exce_result),
    .flag_clr        (flag_clr),
    .trap_en         (trap_en),
    .sticky_flags    (sticky_flags),
    .irq             (irq),
    .exce_count      (exce_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  function automatic void ref_model(input int opc, input int a, input int b,
                                    output int code, output bit exc, output bit ovr,
                                    output logic [7:0] res);
    int ea, ma, sa, eb, mb, sb;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sn, qn, inv, dz;
    ea = (a / 8) % 16; ma = a % 8; sa = a / 128;
    eb = (b / 8) % 16; mb = b % 8; sb = b / 128;
    nan_a  = (ea == 15) && (ma != 0);  nan_b  = (eb == 15) && (mb != 0);
    inf_a  = (ea == 15) && (ma == 0);  inf_b  = (eb == 15) && (mb == 0);
    zero_a = (ea == 0) && (ma == 0);   zero_b = (eb == 0) && (mb == 0);
    sn = (nan_a && ma < 4) || (nan_b && mb < 4);
    qn = (nan_a && ma >= 4) || (nan_b && mb >= 4);
    if (opc == 0)      inv = inf_a && inf_b && (sa != sb);
    else if (opc == 1) inv = inf_a && inf_b && (sa == sb);
    else if (opc == 2) inv = (zero_a && inf_b) || (inf_a && zero_b);
    else               inv = (zero_a && zero_b) || (inf_a && inf_b);
    dz = (opc == 3) && zero_b && !zero_a && (ea != 15);
    res = 8'h00;
    if (sn)       begin code = 1; res = 8'h7C; end
    else if (qn)  begin code = 2; res = nan_a ? 8'(a) : 8'(b); end
    else if (inv) begin code = 3; res = 8'h7C; end
    else if (dz)  begin code = 4; res = 8'(8'h78 + 128 * (sa ^ sb)); end
    else          code = 0;
    exc = (code == 1) || (code == 3) || (code == 4);
    ovr = (code != 0);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_exce = 0; m_code = 0; m_ovr = 0; m_res = '0; m_sticky = '0; m_count = 0;
  endtask

  task automatic drive(input int opc, input int a, input int b);
    in_valid = 1'b1; op = 2'(opc); in0 = 8'(a); in1 = 8'(b);
  endtask

  // One clock: predicts the capture from the current inputs, then samples #1 after the edge.
  task automatic advance();
    int c; bit e, o, fire; logic [7:0] r;
    ref_model(int'(op), int'(in0), int'(in1), c, e, o, r);
    fire = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    if (flag_clr) m_sticky = '0;
    if (fire) begin
      m_valid = 1; m_exce = e; m_code = c; m_ovr = o; m_res = r;
      if (c == 1 || c == 3) m_sticky[0] = 1'b1;
      if (c == 4)           m_sticky[1] = 1'b1;
      if (c == 2)           m_sticky[2] = 1'b1;
      if (e && m_count < 255) m_count++;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; op = 0; in0 = 0; in1 = 0;
    out_ready = 1; flag_clr = 0; trap_en = 3'b111;
    model_reset();
    #3;
    total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (exce !== 1'b0)           begin bad++; $display("FAIL reset_exce got=%0b exp=0", exce); end
    total++; if (exce_code !== 3'd0)      begin bad++; $display("FAIL reset_code got=%0d exp=0", exce_code); end
    total++; if (result_override !== 1'b0) begin bad++; $display("FAIL reset_override got=%0b exp=0", result_override); end
    total++; if (exce_result !== 8'h00)   begin bad++; $display("FAIL reset_result got=%h exp=00", exce_result); end
    total++; if (sticky_flags !== 3'b000) begin bad++; $display("FAIL reset_sticky got=%b exp=000", sticky_flags); end
    total++; if (exce_count !== 8'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", exce_count); end
    total++; if (irq !== 1'b0)            begin bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    total++; if (in_ready !== 1'b1)       begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_snan();
    out_ready = 1; drive(0, 'h79, 'h00); advance(); in_valid = 0;
    total++; if (out_valid !== 1'b1)      begin bad++; $display("FAIL snan_valid got=%0b exp=1", out_valid); end
    total++; if (exce !== 1'b1)           begin bad++; $display("FAIL snan_exce got=%0b exp=1", exce); end
    total++; if (exce_code !== 3'd1)      begin bad++; $display("FAIL snan_code got=%0d exp=1", exce_code); end
    total++; if (exce_result !== 8'h7C)   begin bad++; $display("FAIL snan_result got=%h exp=7c", exce_result); end
    total++; if (sticky_flags !== 3'b001) begin bad++; $display("FAIL snan_sticky got=%b exp=001", sticky_flags); end
    total++; if (exce_count !== 8'd1)     begin bad++; $display("FAIL snan_count got=%0d exp=1", exce_count); end
  endtask

  task automatic test_qnan();
    drive(2, 'h38, 'hFC); advance(); in_valid = 0;
    total++; if (exce !== 1'b0)            begin bad++; $display("FAIL qnan_exce got=%0b exp=0", exce); end
    total++; if (exce_code !== 3'd2)       begin bad++; $display("FAIL qnan_code got=%0d exp=2", exce_code); end
    total++; if (result_override !== 1'b1) begin bad++; $display("FAIL qnan_override got=%0b exp=1", result_override); end
    total++; if (exce_result !== 8'hFC)    begin bad++; $display("FAIL qnan_result got=%h exp=fc", exce_result); end
    total++; if (sticky_flags[2] !== 1'b1) begin bad++; $display("FAIL qnan_sticky2 got=%b exp=1", sticky_flags[2]); end
    total++; if (exce_count !== 8'd1)      begin bad++; $display("FAIL qnan_count got=%0d exp=1", exce_count); end
  endtask

  // Back-to-back sweep: one new item captured and presented every cycle.
  task automatic test_invalid_sweep();
    int         ops  [5] = '{0, 1, 2, 3, 3};
    int         a    [5] = '{'h78, 'h78, 'h00, 'h00, 'hB8};
    int         b    [5] = '{'hF8, 'h78, 'hF8, 'h00, 'h00};
    int         code [5] = '{3, 3, 3, 3, 4};
    logic [7:0] res  [5] = '{8'h7C, 8'h7C, 8'h7C, 8'h7C, 8'hF8};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], a[i], b[i]); advance();
      total++; if (out_valid !== 1'b1)     begin bad++; $display("FAIL sweep%0d_valid got=%0b exp=1", i, out_valid); end
      total++; if (exce_code !== 3'(code[i])) begin bad++; $display("FAIL sweep%0d_code got=%0d exp=%0d", i, exce_code, code[i]); end
      total++; if (exce_result !== res[i]) begin bad++; $display("FAIL sweep%0d_result got=%h exp=%h", i, exce_result, res[i]); end
      total++; if (exce !== 1'b1)          begin bad++; $display("FAIL sweep%0d_exce got=%0b exp=1", i, exce); end
    end
    in_valid = 0;
    total++; if (sticky_flags[1] !== 1'b1) begin bad++; $display("FAIL sweep_sticky1 got=%b exp=1", sticky_flags[1]); end
    total++; if (exce_count !== 8'd6)      begin bad++; $display("FAIL sweep_count got=%0d exp=6", exce_count); end
    advance();
    total++; if (out_valid !== 1'b0)       begin bad++; $display("FAIL sweep_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1; drive(3, 'h00, 'h00); advance();
    out_ready = 0; drive(3, 'hB8, 'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL bp%0d_in_ready got=%0b exp=0", i, in_ready); end
      advance();
      total++; if (out_valid !== 1'b1)    begin bad++; $display("FAIL bp%0d_valid got=%0b exp=1", i, out_valid); end
      total++; if (exce_code !== 3'd3)    begin bad++; $display("FAIL bp%0d_code got=%0d exp=3", i, exce_code); end
      total++; if (exce_result !== 8'h7C) begin bad++; $display("FAIL bp%0d_result got=%h exp=7c", i, exce_result); end
      total++; if (exce_count !== 8'd7)   begin bad++; $display("FAIL bp%0d_count got=%0d exp=7", i, exce_count); end
    end
    out_ready = 1; #1;
    total++; if (in_ready !== 1'b1)       begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    advance(); in_valid = 0;
    total++; if (exce_code !== 3'd4)      begin bad++; $display("FAIL bp_next_code got=%0d exp=4", exce_code); end
    total++; if (exce_result !== 8'hF8)   begin bad++; $display("FAIL bp_next_result got=%h exp=f8", exce_result); end
    total++; if (exce_count !== 8'd8)     begin bad++; $display("FAIL bp_next_count got=%0d exp=8", exce_count); end
    advance();
    total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    total++; if (exce_count !== 8'd8)     begin bad++; $display("FAIL bp_no_dup got=%0d exp=8", exce_count); end
  endtask

  task automatic test_random();
    logic [7:0] pool [10] = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h79, 8'hFA, 8'h7C, 8'hFC, 8'hB8, 8'h01};
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 15) == 0);
      trap_en   = 3'($urandom);
      op        = 2'($urandom);
      in0       = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      in1       = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      #1;
      total++; if (in_ready !== (!m_valid || out_ready)) begin bad++; $display("FAIL rnd%0d_in_ready got=%0b exp=%0b", n, in_ready, !m_valid || out_ready); end
      total++; if (irq !== |(m_sticky & trap_en)) begin bad++; $display("FAIL rnd%0d_irq_pre got=%0b exp=%0b", n, irq, |(m_sticky & trap_en)); end
      advance();
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", n, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (exce !== m_exce)            begin bad++; $display("FAIL rnd%0d_exce got=%0b exp=%0b", n, exce, m_exce); end
        total++; if (exce_code !== 3'(m_code))   begin bad++; $display("FAIL rnd%0d_code got=%0d exp=%0d", n, exce_code, m_code); end
        total++; if (result_override !== m_ovr)  begin bad++; $display("FAIL rnd%0d_override got=%0b exp=%0b", n, result_override, m_ovr); end
        total++; if (exce_result !== m_res)      begin bad++; $display("FAIL rnd%0d_result got=%h exp=%h", n, exce_result, m_res); end
      end
      total++; if (sticky_flags !== m_sticky)    begin bad++; $display("FAIL rnd%0d_sticky got=%b exp=%b", n, sticky_flags, m_sticky); end
      total++; if (exce_count !== 8'(m_count))   begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", n, exce_count, m_count); end
    end
    in_valid = 0; flag_clr = 0; out_ready = 1; advance();
  endtask

  task automatic test_sticky_irq();
    trap_en = 3'b010; flag_clr = 1; in_valid = 0; advance(); flag_clr = 0;
    total++; if (sticky_flags !== 3'b000) begin bad++; $display("FAIL clr_sticky got=%b exp=000", sticky_flags); end
    total++; if (irq !== 1'b0)            begin bad++; $display("FAIL clr_irq got=%0b exp=0", irq); end
    drive(3, 'hB8, 'h00); advance(); in_valid = 0;
    total++; if (sticky_flags !== 3'b010) begin bad++; $display("FAIL dz_sticky got=%b exp=010", sticky_flags); end
    total++; if (irq !== 1'b1)            begin bad++; $display("FAIL dz_irq got=%0b exp=1", irq); end
    flag_clr = 1; drive(0, 'h79, 'h00); advance(); flag_clr = 0; in_valid = 0;
    total++; if (sticky_flags !== 3'b001) begin bad++; $display("FAIL clrset_sticky got=%b exp=001", sticky_flags); end
    total++; if (irq !== 1'b0)            begin bad++; $display("FAIL clrset_irq got=%0b exp=0", irq); end
    drive(0, 'h79, 'h00);
    for (int i = 0; i < 300; i++) advance();
    in_valid = 0;
    total++; if (exce_count !== 8'd255)   begin bad++; $display("FAIL sat_count got=%0d exp=255", exce_count); end
    advance();
    total++; if (exce_count !== 8'd255)   begin bad++; $display("FAIL sat_hold got=%0d exp=255", exce_count); end
  endtask

  task automatic test_async_reset();
    trap_en = 3'b111; out_ready = 1; drive(0, 'h79, 'h00); advance();
    out_ready = 0; in_valid = 0; advance();
    total++; if (out_valid !== 1'b1)      begin bad++; $display("FAIL ar_stall_valid got=%0b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL ar_valid got=%0b exp=0", out_valid); end
    total++; if (exce !== 1'b0)           begin bad++; $display("FAIL ar_exce got=%0b exp=0", exce); end
    total++; if (exce_code !== 3'd0)      begin bad++; $display("FAIL ar_code got=%0d exp=0", exce_code); end
    total++; if (result_override !== 1'b0) begin bad++; $display("FAIL ar_override got=%0b exp=0", result_override); end
    total++; if (exce_result !== 8'h00)   begin bad++; $display("FAIL ar_result got=%h exp=00", exce_result); end
    total++; if (sticky_flags !== 3'b000) begin bad++; $display("FAIL ar_sticky got=%b exp=000", sticky_flags); end
    total++; if (exce_count !== 8'd0)     begin bad++; $display("FAIL ar_count got=%0d exp=0", exce_count); end
    total++; if (irq !== 1'b0)            begin bad++; $display("FAIL ar_irq got=%0b exp=0", irq); end
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1; drive(3, 'hB8, 'h00); advance(); in_valid = 0;
    total++; if (out_valid !== 1'b1)      begin bad++; $display("FAIL ar_post_valid got=%0b exp=1", out_valid); end
    total++; if (exce_code !== 3'd4)      begin bad++; $display("FAIL ar_post_code got=%0d exp=4", exce_code); end
    total++; if (exce_result !== 8'hF8)   begin bad++; $display("FAIL ar_post_result got=%h exp=f8", exce_result); end
    total++; if (exce_count !== 8'd1)     begin bad++; $display("FAIL ar_post_count got=%0d exp=1", exce_count); end
    total++; if (sticky_flags !== 3'b010) begin bad++; $display("FAIL ar_post_sticky got=%b exp=010", sticky_flags); end
  endtask

  initial begin
    test_reset();
    test_snan();
    test_qnan();
    test_invalid_sweep();
    test_backpressure();
    test_random();
    test_sticky_irq();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
